// File: rtl/multi_channel_clk_divider.sv
// N_CH independent 50%-duty clock dividers with runtime divisors and start-of-period ticks.
// Note: rst_n is an asynchronous, active-HIGH reset despite its name (1 = reset).
module multi_channel_clk_divider #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       en,
  input  logic [N_CH*WIDTH-1:0] div_in,
  output logic [N_CH-1:0]       clk_out,
  output logic [N_CH-1:0]       tick,
  output logic [N_CH*WIDTH-1:0] div_cur
);

  logic [WIDTH-1:0] cnt_q     [N_CH];
  logic [WIDTH-1:0] cnt_d     [N_CH];
  logic [WIDTH-1:0] div_act_q [N_CH];
  logic [WIDTH-1:0] div_act_d [N_CH];
  logic [N_CH-1:0]  clk_p_q, clk_p_d;
  logic [N_CH-1:0]  clk_n_q;
  logic [N_CH-1:0]  running;

  // clk_p is computed from the next-state cnt/div_act so it stays aligned with cnt
  // and a divisor change at the wrap can never produce a runt pulse.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      running[i]   = en[i] && (div_act_q[i] != '0);
      cnt_d[i]     = '0;
      div_act_d[i] = div_in[i*WIDTH +: WIDTH];
      clk_p_d[i]   = 1'b0;
      if (running[i]) begin
        if (cnt_q[i] != div_act_q[i] - WIDTH'(1)) begin
          cnt_d[i]     = cnt_q[i] + WIDTH'(1);
          div_act_d[i] = div_act_q[i];
        end
        clk_p_d[i] = (div_act_d[i] != '0) && (cnt_d[i] >= (div_act_d[i] >> 1));
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i]     <= '0;
        div_act_q[i] <= '0;
      end
      clk_p_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i]     <= cnt_d[i];
        div_act_q[i] <= div_act_d[i];
      end
      clk_p_q <= clk_p_d;
    end
  end

  // Half-cycle delayed copy of clk_p; ANDing it in trims odd divisors to an exact N/2 high time.
  always_ff @(negedge clk or posedge rst_n) begin
    if (rst_n) begin
      clk_n_q <= '0;
    end else begin
      clk_n_q <= clk_p_q;
    end
  end

  always_comb begin
    clk_out = '0;
    tick    = '0;
    div_cur = '0;
    for (int i = 0; i < N_CH; i++) begin
      tick[i]                   = running[i] && (cnt_q[i] == '0);
      div_cur[i*WIDTH +: WIDTH] = div_act_q[i];
      if (div_act_q[i] == WIDTH'(1)) begin
        clk_out[i] = en[i] & clk;
      end else if (!div_act_q[i][0]) begin
        clk_out[i] = clk_p_q[i];
      end else begin
        clk_out[i] = clk_p_q[i] & clk_n_q[i];
      end
    end
  end

endmodule

// File: tb/tb_multi_channel_clk_divider.sv
// Directed bench for multi_channel_clk_divider: hand-computed period/duty counts plus a
// per-channel behavioural model checked on both clock phases.
module tb_multi_channel_clk_divider;

  localparam int N_CH  = 4;
  localparam int WIDTH = 8;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [N_CH-1:0]       en;
  logic [N_CH*WIDTH-1:0] div_in;
  logic [N_CH-1:0]       clk_out;
  logic [N_CH-1:0]       tick;
  logic [N_CH*WIDTH-1:0] div_cur;

  multi_channel_clk_divider #(.N_CH(N_CH), .WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .div_in  (div_in),
    .clk_out (clk_out),
    .tick    (tick),
    .div_cur (div_cur)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int m_cnt [N_CH];
  int m_div [N_CH];
  bit m_p   [N_CH];
  bit m_n   [N_CH];

  // Samples from the most recent cycle
  logic [N_CH-1:0] s_hi_clk, s_lo_clk, s_hi_tick;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N_CH; i++) begin
      m_cnt[i] = 0;
      m_div[i] = 0;
      m_p[i]   = 1'b0;
      m_n[i]   = 1'b0;
    end
  endtask

  task automatic model_posedge();
    int d_in;
    if (rst_n) begin
      model_clear();
      return;
    end
    for (int i = 0; i < N_CH; i++) begin
      d_in = int'(div_in[i*WIDTH +: WIDTH]);
      if (!en[i] || m_div[i] == 0) begin
        m_cnt[i] = 0;
        m_div[i] = d_in;
        m_p[i]   = 1'b0;
      end else begin
        if (m_cnt[i] == m_div[i] - 1) begin
          m_cnt[i] = 0;
          m_div[i] = d_in;
        end else begin
          m_cnt[i] = m_cnt[i] + 1;
        end
        m_p[i] = (m_div[i] != 0) && (m_cnt[i] >= m_div[i] / 2);
      end
    end
  endtask

  function automatic bit exp_clk(input int i);
    if (m_div[i] == 1) return en[i] && clk;
    if (m_div[i] % 2 == 0) return m_p[i];
    return m_p[i] && m_n[i];
  endfunction

  task automatic check_all(input string ph);
    logic [N_CH-1:0]       e_clk, e_tick;
    logic [N_CH*WIDTH-1:0] e_div;
    for (int i = 0; i < N_CH; i++) begin
      e_clk[i]                = exp_clk(i);
      e_tick[i]               = en[i] && (m_div[i] != 0) && (m_cnt[i] == 0);
      e_div[i*WIDTH +: WIDTH] = WIDTH'(m_div[i]);
    end
    chk({ph, " clk_out"}, 64'(clk_out), 64'(e_clk));
    chk({ph, " tick"},    64'(tick),    64'(e_tick));
    chk({ph, " div_cur"}, 64'(div_cur), 64'(e_div));
  endtask

  // One clock: model + check in the high phase, then in the low phase; returns at negedge+2.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_posedge();
    #2;
    s_hi_clk  = clk_out;
    s_hi_tick = tick;
    check_all({tag, "/hi"});
    @(negedge clk);
    for (int i = 0; i < N_CH; i++) m_n[i] = rst_n ? 1'b0 : m_p[i];
    #2;
    s_lo_clk = clk_out;
    check_all({tag, "/lo"});
  endtask

  // Run n cycles counting high-phase clk_out, low-phase clk_out and ticks on one channel.
  task automatic measure(input int ch, input int n, input string tag,
                         input int e_hi, input int e_lo, input int e_tick);
    int hi = 0, lo = 0, tk = 0;
    for (int k = 0; k < n; k++) begin
      cycle(tag);
      hi += int'(s_hi_clk[ch]);
      lo += int'(s_lo_clk[ch]);
      tk += int'(s_hi_tick[ch]);
    end
    chk({tag, " high_phase_count"}, 64'(hi), 64'(e_hi));
    chk({tag, " low_phase_count"},  64'(lo), 64'(e_lo));
    chk({tag, " tick_count"},       64'(tk), 64'(e_tick));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    rst_n  = 1'b1;
    en     = '0;
    div_in = '0;

    // Reset state
    cycle("reset");
    cycle("reset");
    chk("reset clk_out", 64'(clk_out), 64'd0);
    chk("reset tick",    64'(tick),    64'd0);
    chk("reset div_cur", 64'(div_cur), 64'd0);
    rst_n = 1'b0;

    // 1: divisor 4, first tick one clock after enable
    en[0]         = 1'b1;
    div_in[7:0]   = 8'd4;
    cycle("div4_first");
    chk("div4 first tick",  64'(tick[0]),     64'd1);
    chk("div4 first div",   64'(div_cur[7:0]), 64'd4);
    cycle("div4"); cycle("div4"); cycle("div4");
    measure(0, 4, "div4_period", 2, 2, 1);

    // 2: divisor 5 taken at the wrap; high 2.5 clocks
    div_in[7:0] = 8'd5;
    measure(0, 5, "div5_period", 2, 3, 1);
    chk("div5 div_cur", 64'(div_cur[7:0]), 64'd5);

    // 3: 4 -> 6 requested at cnt==1 only takes effect at the wrap
    div_in[7:0] = 8'd4;
    measure(0, 4, "div4_again", 2, 2, 1);
    cycle("div4_c0");
    cycle("div4_c1");
    div_in[7:0] = 8'd6;
    cycle("div4_c2");
    cycle("div4_c3");
    chk("div6 pending div_cur", 64'(div_cur[7:0]), 64'd4);
    measure(0, 6, "div6_period", 3, 3, 1);
    chk("div6 div_cur", 64'(div_cur[7:0]), 64'd6);

    // 4: divisor 1 passes clk, then divisor 0 parks the channel
    div_in[7:0] = 8'd1;
    measure(0, 4, "div1", 4, 0, 4);
    div_in[7:0] = 8'd0;
    measure(0, 3, "div0_park", 0, 0, 0);
    chk("park div_cur", 64'(div_cur[7:0]), 64'd0);

    // 5: maximum divisor 255, two full periods
    div_in[7:0] = 8'd255;
    measure(0, 255, "div255_a", 127, 128, 1);
    measure(0, 255, "div255_b", 127, 128, 1);

    // 6: four channels 2/3/7/8 with random enables and a mid-period async reset
    div_in = {8'd8, 8'd7, 8'd3, 8'd2};
    en     = 4'b1111;
    for (int k = 0; k < 120; k++) begin
      cycle("multi_a");
      for (int i = 0; i < N_CH; i++)
        if ($urandom_range(0, 7) == 0) en[i] = ~en[i];
    end
    #1;
    rst_n = 1'b1;
    model_clear();
    #1;
    chk("async reset clk_out", 64'(clk_out), 64'd0);
    chk("async reset tick",    64'(tick),    64'd0);
    chk("async reset div_cur", 64'(div_cur), 64'd0);
    cycle("multi_rst");
    cycle("multi_rst");
    rst_n = 1'b0;
    en    = 4'b1111;
    for (int k = 0; k < 120; k++) begin
      cycle("multi_b");
      for (int i = 0; i < N_CH; i++)
        if ($urandom_range(0, 7) == 0) en[i] = ~en[i];
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
